// File: rtl/onchip_mem_s2_arbiter.sv
// Round-robin arbiter and command sequencer for the on-chip memory s2 port, with a tag
// pipeline that routes read data back to its issuer. Define ONCHIP_ARB_PERF_CNT_EN for the performance counters.
module onchip_mem_s2_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 64
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_byteen,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_byteen,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_W-1:0]     b_rdata,
`ifdef ONCHIP_ARB_PERF_CNT_EN
    input  logic                  perf_clr,
    output logic [31:0]           perf_gnt_a,
    output logic [31:0]           perf_gnt_b,
    output logic [31:0]           perf_conflict,
`endif
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_clken,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    req_id_t                last_gnt;
    req_id_t                winner;
    logic                   grant_a;
    logic                   grant_b;
    logic                   any_gnt;
    logic                   win_write;
    logic [ADDR_W-1:0]      win_addr;
    logic [DATA_W-1:0]      win_wdata;
    logic [DATA_W/8-1:0]    win_byteen;
    logic [READ_LATENCY:0]  tag_valid;
    logic [READ_LATENCY:0]  tag_id;

    // On a conflict the requester that did not win last time is served.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        winner  = REQ_A;
        if (!reset_reset) begin
            if (a_req && b_req) begin
                if (last_gnt == REQ_B) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
        if (grant_b) begin
            winner = REQ_B;
        end
    end

    assign any_gnt    = grant_a | grant_b;
    assign a_gnt      = grant_a;
    assign b_gnt      = grant_b;
    assign win_write  = grant_b ? b_write  : a_write;
    assign win_addr   = grant_b ? b_addr   : a_addr;
    assign win_wdata  = grant_b ? b_wdata  : a_wdata;
    assign win_byteen = grant_b ? b_byteen : a_byteen;
    assign mem_clken  = 1'b1;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            last_gnt       <= REQ_B;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
        end else if (any_gnt) begin
            last_gnt       <= winner;
            mem_chipselect <= 1'b1;
            mem_write      <= win_write;
            mem_address    <= win_addr;
            mem_writedata  <= win_wdata;
            mem_byteenable <= win_byteen;
        end else begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
        end
    end

    // One extra stage beyond the memory latency covers the command register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid <= {tag_valid[READ_LATENCY-1:0], any_gnt & ~win_write};
            tag_id    <= {tag_id[READ_LATENCY-1:0], winner == REQ_B};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= tag_valid[READ_LATENCY] & ~tag_id[READ_LATENCY];
            b_rvalid <= tag_valid[READ_LATENCY] &  tag_id[READ_LATENCY];
            if (tag_valid[READ_LATENCY] && !tag_id[READ_LATENCY]) begin
                a_rdata <= mem_readdata;
            end
            if (tag_valid[READ_LATENCY] && tag_id[READ_LATENCY]) begin
                b_rdata <= mem_readdata;
            end
        end
    end

`ifdef ONCHIP_ARB_PERF_CNT_EN
    // Saturating counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || perf_clr) begin
            perf_gnt_a    <= '0;
            perf_gnt_b    <= '0;
            perf_conflict <= '0;
        end else begin
            if (grant_a && perf_gnt_a != 32'hFFFF_FFFF) begin
                perf_gnt_a <= perf_gnt_a + 32'd1;
            end
            if (grant_b && perf_gnt_b != 32'hFFFF_FFFF) begin
                perf_gnt_b <= perf_gnt_b + 32'd1;
            end
            if (a_req && b_req && perf_conflict != 32'hFFFF_FFFF) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_onchip_mem_s2_arbiter.sv
// Self-checking bench for onchip_mem_s2_arbiter: directed plan items plus randomized
// traffic against a transaction-level model (shadow memory and a queue of pending returns).
module tb_onchip_mem_s2_arbiter;

    localparam int RL = 1;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        a_req = 1'b0, a_write = 1'b0;
    logic [14:0] a_addr = '0;
    logic [63:0] a_wdata = '0;
    logic [7:0]  a_byteen = '0;
    logic        a_gnt, a_rvalid;
    logic [63:0] a_rdata;
    logic        b_req = 1'b0, b_write = 1'b0;
    logic [14:0] b_addr = '0;
    logic [63:0] b_wdata = '0;
    logic [7:0]  b_byteen = '0;
    logic        b_gnt, b_rvalid;
    logic [63:0] b_rdata;
    logic [14:0] mem_address;
    logic        mem_chipselect, mem_clken, mem_write;
    logic [63:0] mem_writedata;
    logic [7:0]  mem_byteenable;
    logic [63:0] mem_readdata;
`ifdef ONCHIP_ARB_PERF_CNT_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_gnt_a, perf_gnt_b, perf_conflict;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    onchip_mem_s2_arbiter #(.READ_LATENCY(RL), .ADDR_W(15), .DATA_W(64)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_byteen(a_byteen), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_byteen(b_byteen), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef ONCHIP_ARB_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_gnt_a(perf_gnt_a), .perf_gnt_b(perf_gnt_b),
        .perf_conflict(perf_conflict),
`endif
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_clken(mem_clken), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    // s2 memory with RL cycles of read latency after the sampling edge
    logic [63:0] ram [0:32767];
    logic [63:0] rd_pipe [0:1];
    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = '0;
        rd_pipe[0] = '0;
        rd_pipe[1] = '0;
    end
    always @(posedge clk_clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int k = 0; k < 8; k++)
                    if (mem_byteenable[k]) ram[mem_address][8*k +: 8] <= mem_writedata[8*k +: 8];
            end else begin
                rd_pipe[0] <= ram[mem_address];
            end
        end
        rd_pipe[1] <= rd_pipe[0];
    end
    assign mem_readdata = rd_pipe[RL-1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Transaction-level model: grant rule, shadow memory updated at grant time, return queue.
    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } ret_t;

    ret_t        rq[$];
    logic [63:0] shadow [0:32767];
    bit          model_on = 0;
    int          m_last;
    bit          m_cs;
    logic        m_cw;
    logic [14:0] m_ca;
    logic [63:0] m_cd;
    logic [7:0]  m_cb;
    logic [63:0] m_rdata [0:1];
    int          gnt_log[$];
    int          rv_log[$];
    int          rv_cyc [0:1];
    int          rv_cnt [0:1];

    initial begin
        for (int i = 0; i < 32768; i++) shadow[i] = '0;
        rv_cnt[0] = 0;
        rv_cnt[1] = 0;
        rv_cyc[0] = -100;
        rv_cyc[1] = -100;
    end

    always @(negedge clk_clk) begin
        bit          ega, egb;
        logic [1:0]  erv;
        int          wid;
        logic        ww;
        logic [14:0] wa;
        logic [63:0] wd;
        logic [7:0]  wb;
        if (model_on) begin
            ega = 0;
            egb = 0;
            if (!reset_reset) begin
                if (a_req && b_req) begin
                    ega = (m_last == 1);
                    egb = (m_last == 0);
                end else begin
                    ega = a_req;
                    egb = b_req;
                end
            end
            checkOutput("a_gnt", a_gnt, ega);
            checkOutput("b_gnt", b_gnt, egb);
            erv = 2'b00;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv[rq[0].id] = 1'b1;
                m_rdata[rq[0].id] = rq[0].data;
                void'(rq.pop_front());
            end
            checkOutput("a_rvalid", a_rvalid, erv[0]);
            checkOutput("b_rvalid", b_rvalid, erv[1]);
            checkOutput("a_rdata", a_rdata, m_rdata[0]);
            checkOutput("b_rdata", b_rdata, m_rdata[1]);
            checkOutput("mem_chipselect", mem_chipselect, m_cs);
            checkOutput("mem_clken", mem_clken, 1'b1);
            checkOutput("mem_write", mem_write, m_cs ? m_cw : 1'b0);
            if (m_cs) begin
                checkOutput("mem_address", mem_address, m_ca);
                checkOutput("mem_writedata", mem_writedata, m_cd);
                checkOutput("mem_byteenable", mem_byteenable, m_cb);
            end
            if (a_gnt === 1'b1) gnt_log.push_back(0);
            if (b_gnt === 1'b1) gnt_log.push_back(1);
            if (a_rvalid === 1'b1) begin rv_log.push_back(0); rv_cyc[0] = cyc; rv_cnt[0]++; end
            if (b_rvalid === 1'b1) begin rv_log.push_back(1); rv_cyc[1] = cyc; rv_cnt[1]++; end
            if (reset_reset) begin
                rq.delete();
                m_last = 1;
                m_cs = 0;
                m_rdata[0] = '0;
                m_rdata[1] = '0;
            end else if (ega || egb) begin
                wid = egb ? 1 : 0;
                ww  = egb ? b_write  : a_write;
                wa  = egb ? b_addr   : a_addr;
                wd  = egb ? b_wdata  : a_wdata;
                wb  = egb ? b_byteen : a_byteen;
                if (ww) begin
                    for (int k = 0; k < 8; k++)
                        if (wb[k]) shadow[wa][8*k +: 8] = wd[8*k +: 8];
                end else begin
                    rq.push_back('{id: wid, data: shadow[wa], due: cyc + 2 + RL});
                end
                m_last = wid;
                m_cs = 1;
                m_cw = ww;
                m_ca = wa;
                m_cd = wd;
                m_cb = wb;
            end else begin
                m_cs = 0;
            end
        end else if (reset_reset) begin
            rq.delete();
            m_last = 1;
            m_cs = 0;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            model_on = 1;
        end
    end

    // Holds the given inputs for one clock, returning #1 after the edge.
    task automatic applyStimulus(input bit ra, input bit wa_, input logic [14:0] aa, input logic [63:0] da,
                                 input logic [7:0] ea, input bit rb, input bit wb_, input logic [14:0] ab,
                                 input logic [63:0] db, input logic [7:0] eb);
        a_req = ra; a_write = wa_; a_addr = aa; a_wdata = da; a_byteen = ea;
        b_req = rb; b_write = wb_; b_addr = ab; b_wdata = db; b_byteen = eb;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic doReset(input int n);
        reset_reset = 1'b1;
        idle(n);
        reset_reset = 1'b0;
    endtask

    task automatic issue(input int id, input bit w, input logic [14:0] ad, input logic [63:0] d,
                         input logic [7:0] be, output int gcyc);
        bit got = 0;
        gcyc = -1;
        if (id == 0) begin
            a_req = 1; a_write = w; a_addr = ad; a_wdata = d; a_byteen = be; b_req = 0;
        end else begin
            b_req = 1; b_write = w; b_addr = ad; b_wdata = d; b_byteen = be; a_req = 0;
        end
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk_clk);
            if ((id == 0 ? a_gnt : b_gnt) === 1'b1) begin
                got = 1;
                gcyc = cyc;
            end
            @(posedge clk_clk);
            #1;
        end
        a_req = 0;
        b_req = 0;
        if (!got) checkOutput("issue_timeout", 0, 1);
    endtask

    initial begin
        int g;
        int rv_before;
        doReset(3);
        @(negedge clk_clk);
        checkOutput("rst_mem_chipselect", mem_chipselect, 1'b0);
        checkOutput("rst_mem_clken", mem_clken, 1'b1);
        checkOutput("rst_mem_address", mem_address, 15'h0);
        checkOutput("rst_mem_writedata", mem_writedata, 64'h0);
        checkOutput("rst_a_rdata", a_rdata, 64'h0);
        checkOutput("rst_b_rvalid", b_rvalid, 1'b0);
        @(posedge clk_clk);
        #1;

        // write then read across requesters
        rv_before = rv_cnt[0];
        issue(0, 1, 15'h0010, 64'h0123456789ABCDEF, 8'hFF, g);
        issue(1, 0, 15'h0010, 64'h0, 8'hFF, g);
        idle(6);
        checkOutput("t1_b_latency", rv_cyc[1] - g, 2 + RL);
        checkOutput("t1_b_rdata", b_rdata, 64'h0123456789ABCDEF);
        checkOutput("t1_a_rvalid_none", rv_cnt[0], rv_before);

        // partial write then read back
        issue(0, 1, 15'h0010, 64'hFFFFFFFFFFFFFFFF, 8'h0F, g);
        issue(0, 0, 15'h0010, 64'h0, 8'hFF, g);
        idle(6);
        checkOutput("t2_a_rdata", a_rdata, 64'h01234567FFFFFFFF);

        // sustained conflict after reset
        for (int i = 0; i < 8; i++) begin
            issue(0, 1, 15'h0100 + 15'(i), {32'hAAAA0000, 32'(i)}, 8'hFF, g);
            issue(1, 1, 15'h0200 + 15'(i), {32'hBBBB0000, 32'(i)}, 8'hFF, g);
        end
        doReset(1);
        gnt_log.delete();
        rv_log.delete();
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 0, 15'h0100 + 15'(i), '0, 8'hFF, 1, 0, 15'h0200 + 15'(i), '0, 8'hFF);
        idle(6);
        checkOutput("t3_gnt_count", gnt_log.size(), 8);
        checkOutput("t3_rv_count", rv_log.size(), 8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) checkOutput("t3_gnt_order", gnt_log[i], i % 2);
        for (int i = 0; i < 8 && i < rv_log.size(); i++) checkOutput("t3_rv_order", rv_log[i], i % 2);
        checkOutput("t3_last_b_rdata", b_rdata, 64'hBBBB000000000007);
        checkOutput("t3_last_a_rdata", a_rdata, 64'hAAAA000000000006);

        // reset before outstanding reads return
        rv_before = rv_cnt[0] + rv_cnt[1];
        applyStimulus(1, 0, 15'h0101, '0, 8'hFF, 0, 0, '0, '0, '0);
        applyStimulus(0, 0, '0, '0, '0, 1, 0, 15'h0202, '0, 8'hFF);
        doReset(1);
        idle(6);
        checkOutput("t4_no_rvalid", rv_cnt[0] + rv_cnt[1], rv_before);
        checkOutput("t4_chipselect", mem_chipselect, 1'b0);
        gnt_log.delete();
        applyStimulus(1, 0, 15'h0001, '0, 8'hFF, 1, 0, 15'h0002, '0, 8'hFF);
        idle(5);
        checkOutput("t4_first_conflict_a", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);

        // randomized traffic with occasional resets and read-after-write overlap
        for (int i = 0; i < 500; i++) begin
            reset_reset = ($urandom_range(0, 63) == 0);
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 15'($urandom_range(0, 15)),
                          {$urandom, $urandom}, 8'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, 15'($urandom_range(0, 15)),
                          {$urandom, $urandom}, 8'($urandom));
        end
        reset_reset = 1'b0;
        idle(6);

`ifdef ONCHIP_ARB_PERF_CNT_EN
        doReset(2);
        repeat (5) applyStimulus(1, 0, 15'h0003, '0, 8'hFF, 1, 0, 15'h0004, '0, 8'hFF);
        a_req = 0;
        b_req = 0;
        checkOutput("perf_conflict", perf_conflict, 32'd5);
        checkOutput("perf_gnt_a", perf_gnt_a, 32'd3);
        checkOutput("perf_gnt_b", perf_gnt_b, 32'd2);
        perf_clr = 1'b1;
        @(posedge clk_clk);
        #1;
        perf_clr = 1'b0;
        checkOutput("perf_clr_conflict", perf_conflict, 32'd0);
        checkOutput("perf_clr_gnt_a", perf_gnt_a, 32'd0);
        checkOutput("perf_clr_gnt_b", perf_gnt_b, 32'd0);
        idle(6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
